zfo_sprite_fetch: RTL and testbench



---
 rtl/zfo_sprite_fetch.sv | 203 ++++++++++++++++++++
 tb/tb_zfo_sprite_fetch.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zfo_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : zfo_sprite_fetch
// Purpose  : Fighter-sprite front end. Frame-rate pose state machine plus a
//            two-stage per-pixel sprite-ROM address / colour-index pipeline
//            that feeds the per-pose zfo palette lookups.
// Options  : ZFO_MIRROR_EN - when defined, facing_left mirrors the sprite
//            column; when undefined, facing_left is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module zfo_sprite_fetch #(
  parameter int SPR_W         = 96,
  parameter int SPR_H         = 128,
  parameter int ROM_AW        = 14,
  parameter int ATTACK_FRAMES = 12,
  parameter int JUMP_FRAMES   = 30
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk_en,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_jump,
  input  logic              btn_crouch,
  input  logic              btn_punch,
  input  logic              btn_kick,
  input  logic              btn_block,
  input  logic              health_zero,
  input  logic              facing_left,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pose_sel,
  output logic [3:0]        pix_index,
  output logic              pix_inside,
  output logic              attack_active
);

  // Counter must hold the larger of the two hold lengths minus one.
  localparam int C_MAXF  = (ATTACK_FRAMES > JUMP_FRAMES) ? ATTACK_FRAMES : JUMP_FRAMES;
  localparam int C_CNT_W = $clog2(C_MAXF + 1);
  localparam logic [C_CNT_W-1:0] C_ATK_LOAD = C_CNT_W'(ATTACK_FRAMES - 1);
  localparam logic [C_CNT_W-1:0] C_JMP_LOAD = C_CNT_W'(JUMP_FRAMES - 1);

  typedef enum logic [3:0] {
    POSE_STAND       = 4'd0,
    POSE_MOVE        = 4'd1,
    POSE_JUMP        = 4'd2,
    POSE_CROUCH      = 4'd3,
    POSE_PUNCH       = 4'd4,
    POSE_KICK        = 4'd5,
    POSE_CROUCHPUNCH = 4'd6,
    POSE_BLOCK       = 4'd7,
    POSE_DEAD        = 4'd8
  } pose_t;

  pose_t               r_pose;
  pose_t               w_pose_nx;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [C_CNT_W-1:0]  w_cnt_nx;

  // Pose and hold-counter state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pose <= POSE_STAND;
      r_cnt  <= '0;
    end else begin
      r_pose <= w_pose_nx;
      r_cnt  <= w_cnt_nx;
    end
  end

  // Next-pose decode; only evaluated on frame pulses so a frame shows one pose.
  always_comb begin
    w_pose_nx = r_pose;
    w_cnt_nx  = r_cnt;
    if (frame_clk_en) begin
      if (health_zero) begin
        w_pose_nx = POSE_DEAD;
      end else begin
        case (r_pose)
          POSE_STAND, POSE_MOVE: begin
            if (btn_punch) begin
              w_pose_nx = POSE_PUNCH;
              w_cnt_nx  = C_ATK_LOAD;
            end else if (btn_kick) begin
              w_pose_nx = POSE_KICK;
              w_cnt_nx  = C_ATK_LOAD;
            end else if (btn_jump) begin
              w_pose_nx = POSE_JUMP;
              w_cnt_nx  = C_JMP_LOAD;
            end else if (btn_crouch) begin
              w_pose_nx = POSE_CROUCH;
            end else if (btn_block) begin
              w_pose_nx = POSE_BLOCK;
            end else if (btn_left ^ btn_right) begin
              w_pose_nx = POSE_MOVE;
            end else begin
              w_pose_nx = POSE_STAND;
            end
          end
          POSE_PUNCH, POSE_KICK, POSE_JUMP: begin
            if (r_cnt == '0) begin
              w_pose_nx = POSE_STAND;
            end else begin
              w_cnt_nx = r_cnt - 1'b1;
            end
          end
          POSE_CROUCH: begin
            if (btn_punch) begin
              w_pose_nx = POSE_CROUCHPUNCH;
              w_cnt_nx  = C_ATK_LOAD;
            end else if (!btn_crouch) begin
              w_pose_nx = POSE_STAND;
            end
          end
          POSE_CROUCHPUNCH: begin
            if (r_cnt == '0) begin
              w_pose_nx = btn_crouch ? POSE_CROUCH : POSE_STAND;
            end else begin
              w_cnt_nx = r_cnt - 1'b1;
            end
          end
          POSE_BLOCK: begin
            if (!btn_block) begin
              w_pose_nx = POSE_STAND;
            end
          end
          POSE_DEAD: begin
            w_pose_nx = POSE_DEAD;
          end
          default: begin
            w_pose_nx = POSE_STAND;
            w_cnt_nx  = '0;
          end
        endcase
      end
    end
  end

  assign pose_sel      = r_pose;
  assign attack_active = (r_pose == POSE_PUNCH) || (r_pose == POSE_KICK) ||
                         (r_pose == POSE_CROUCHPUNCH);

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------------
  logic [10:0]       w_rel_x;
  logic [10:0]       w_rel_y;
  logic              w_inside;
  logic [9:0]        w_col;
  logic [ROM_AW-1:0] w_addr;
  logic              r_inside;
  logic              r_inside_d;
  logic [ROM_AW-1:0] r_rom_addr;

  // Sprite-relative coordinates, box test and ROM address for this pixel.
  always_comb begin
    w_rel_x  = {1'b0, DrawX} - {1'b0, sprite_x};
    w_rel_y  = {1'b0, DrawY} - {1'b0, sprite_y};
    // Bit 10 set means the pixel lies left of / above the sprite origin.
    w_inside = !w_rel_x[10] && (w_rel_x[9:0] < 10'(SPR_W)) &&
               !w_rel_y[10] && (w_rel_y[9:0] < 10'(SPR_H));
`ifdef ZFO_MIRROR_EN
    w_col    = facing_left ? (10'(SPR_W - 1) - w_rel_x[9:0]) : w_rel_x[9:0];
`else
    w_col    = w_rel_x[9:0];
`endif
    // Arithmetic at ROM_AW width equals truncation of the full-width result.
    w_addr   = ROM_AW'(w_rel_y[9:0]) * ROM_AW'(SPR_W) + ROM_AW'(w_col);
    if (!w_inside) begin
      w_addr = '0;
    end
  end

`ifndef ZFO_MIRROR_EN
  logic w_unused_facing;
  assign w_unused_facing = facing_left;
`endif

  // Stage 1 registers the address, stage 2 delays the inside flag to meet ROM data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rom_addr <= '0;
      r_inside   <= 1'b0;
      r_inside_d <= 1'b0;
    end else begin
      r_rom_addr <= w_addr;
      r_inside   <= w_inside;
      r_inside_d <= r_inside;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign pix_inside = r_inside_d;
  // ROM data returns in the same cycle the delayed inside flag becomes valid.
  assign pix_index  = r_inside_d ? rom_data : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_zfo_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_zfo_sprite_fetch
// Purpose  : Directed self-checking bench for zfo_sprite_fetch (pose FSM and
//            pixel pipeline). Honors ZFO_MIRROR_EN for mirrored expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zfo_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk_en;
  logic        btn_left, btn_right, btn_jump, btn_crouch;
  logic        btn_punch, btn_kick, btn_block;
  logic        health_zero, facing_left;
  logic [9:0]  sprite_x, sprite_y, DrawX, DrawY;
  logic [13:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  pose_sel, pix_index;
  logic        pix_inside, attack_active;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  zfo_sprite_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk_en(frame_clk_en),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .btn_crouch(btn_crouch), .btn_punch(btn_punch), .btn_kick(btn_kick),
    .btn_block(btn_block), .health_zero(health_zero), .facing_left(facing_left),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .DrawX(DrawX), .DrawY(DrawY),
    .rom_addr(rom_addr), .rom_data(rom_data), .pose_sel(pose_sel),
    .pix_index(pix_index), .pix_inside(pix_inside), .attack_active(attack_active)
  );

  // Synchronous-read ROM model with an address-dependent pattern.
  function automatic logic [3:0] rom_f(input logic [13:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ {2'b00, a[13:12]};
  endfunction

  always @(posedge Clk) rom_data <= rom_f(rom_addr);

  function automatic logic exp_in(input int dx, input int dy, input int sx, input int sy);
    int rx, ry;
    rx = dx - sx;
    ry = dy - sy;
    return (rx >= 0) && (rx < 96) && (ry >= 0) && (ry < 128);
  endfunction

  function automatic int exp_addr(input int dx, input int dy, input int sx, input int sy,
                                  input logic fl);
    int rx, ry, col;
    rx  = dx - sx;
    ry  = dy - sy;
    col = rx;
`ifdef ZFO_MIRROR_EN
    if (fl) col = 95 - rx;
`else
    if (fl) col = rx;
`endif
    if (!exp_in(dx, dy, sx, sy)) return 0;
    return (ry * 96 + col) % 16384;
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic frame;
    frame_clk_en = 1'b1;
    tick();
    frame_clk_en = 1'b0;
  endtask

  task automatic clear_buttons;
    btn_left = 0; btn_right = 0; btn_jump = 0; btn_crouch = 0;
    btn_punch = 0; btn_kick = 0; btn_block = 0; health_zero = 0;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    frame_clk_en = 1'b0;
    clear_buttons();
    facing_left = 0; sprite_x = 0; sprite_y = 0; DrawX = 0; DrawY = 0;
    tick(); tick();
    checks++;
    if (pose_sel !== 4'd0 || pix_inside !== 1'b0 || rom_addr !== 14'd0 ||
        pix_index !== 4'd0 || attack_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pose=%0d inside=%b addr=%0d idx=%0d atk=%b expected 0/0/0/0/0",
               pose_sel, pix_inside, rom_addr, pix_index, attack_active);
    end
    // Reset held while a frame pulse with punch arrives.
    btn_punch = 1'b1;
    frame();
    btn_punch = 1'b0;
    checks++;
    if (pose_sel !== 4'd0 || attack_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_frame pose=%0d atk=%b expected 0/0", pose_sel, attack_active);
    end
    Reset_n = 1'b1;
    tick();
    checks++;
    if (pose_sel !== 4'd0) begin
      errors++;
      $display("FAIL reset_release pose=%0d expected 0", pose_sel);
    end
  endtask

  task automatic test_punch;
    btn_punch = 1'b1;
    tick();  // no frame pulse: pose must not move
    checks++;
    if (pose_sel !== 4'd0) begin
      errors++;
      $display("FAIL no_frame_gate pose=%0d expected 0", pose_sel);
    end
    frame();
    btn_punch = 1'b0;
    btn_jump  = 1'b1;  // ignored during the hold
    checks++;
    if (pose_sel !== 4'd4 || attack_active !== 1'b1) begin
      errors++;
      $display("FAIL punch_entry pose=%0d atk=%b expected 4/1", pose_sel, attack_active);
    end
    for (int k = 1; k < 12; k++) begin
      frame();
      checks++;
      if (pose_sel !== 4'd4 || attack_active !== 1'b1) begin
        errors++;
        $display("FAIL punch_hold k=%0d pose=%0d atk=%b expected 4/1", k, pose_sel, attack_active);
      end
    end
    frame();
    btn_jump = 1'b0;
    checks++;
    if (pose_sel !== 4'd0 || attack_active !== 1'b0) begin
      errors++;
      $display("FAIL punch_exit pose=%0d atk=%b expected 0/0", pose_sel, attack_active);
    end
  endtask

  task automatic test_crouchpunch(input logic keep_crouch);
    btn_crouch = 1'b1;
    frame();
    checks++;
    if (pose_sel !== 4'd3) begin
      errors++;
      $display("FAIL crouch_entry pose=%0d expected 3", pose_sel);
    end
    btn_punch = 1'b1;
    frame();
    btn_punch = 1'b0;
    if (!keep_crouch) btn_crouch = 1'b0;
    checks++;
    if (pose_sel !== 4'd6 || attack_active !== 1'b1) begin
      errors++;
      $display("FAIL cpunch_entry pose=%0d atk=%b expected 6/1", pose_sel, attack_active);
    end
    for (int k = 1; k < 12; k++) begin
      frame();
      checks++;
      if (pose_sel !== 4'd6) begin
        errors++;
        $display("FAIL cpunch_hold k=%0d pose=%0d expected 6", k, pose_sel);
      end
    end
    frame();
    checks++;
    if (pose_sel !== (keep_crouch ? 4'd3 : 4'd0)) begin
      errors++;
      $display("FAIL cpunch_exit crouch=%b pose=%0d expected %0d", keep_crouch, pose_sel,
               keep_crouch ? 3 : 0);
    end
    btn_crouch = 1'b0;
    frame();
    checks++;
    if (pose_sel !== 4'd0) begin
      errors++;
      $display("FAIL crouch_release pose=%0d expected 0", pose_sel);
    end
  endtask

  task automatic test_move_block;
    btn_left = 1'b1;
    frame();
    checks++;
    if (pose_sel !== 4'd1) begin
      errors++;
      $display("FAIL move_left pose=%0d expected 1", pose_sel);
    end
    btn_right = 1'b1;
    frame();
    checks++;
    if (pose_sel !== 4'd0) begin
      errors++;
      $display("FAIL left_and_right pose=%0d expected 0", pose_sel);
    end
    btn_left = 1'b0; btn_right = 1'b0;
    btn_block = 1'b1;
    frame(); frame();
    checks++;
    if (pose_sel !== 4'd7) begin
      errors++;
      $display("FAIL block_hold pose=%0d expected 7", pose_sel);
    end
    btn_block = 1'b0;
    frame();
    checks++;
    if (pose_sel !== 4'd0) begin
      errors++;
      $display("FAIL block_release pose=%0d expected 0", pose_sel);
    end
    btn_kick = 1'b1;
    frame();
    btn_kick = 1'b0;
    checks++;
    if (pose_sel !== 4'd5 || attack_active !== 1'b1) begin
      errors++;
      $display("FAIL kick_entry pose=%0d atk=%b expected 5/1", pose_sel, attack_active);
    end
    for (int k = 0; k < 12; k++) frame();
    checks++;
    if (pose_sel !== 4'd0) begin
      errors++;
      $display("FAIL kick_exit pose=%0d expected 0", pose_sel);
    end
  endtask

  task automatic test_dead;
    btn_jump = 1'b1;
    frame();
    btn_jump = 1'b0;
    checks++;
    if (pose_sel !== 4'd2 || attack_active !== 1'b0) begin
      errors++;
      $display("FAIL jump_entry pose=%0d atk=%b expected 2/0", pose_sel, attack_active);
    end
    for (int k = 0; k < 5; k++) frame();
    checks++;
    if (pose_sel !== 4'd2) begin
      errors++;
      $display("FAIL jump_hold pose=%0d expected 2", pose_sel);
    end
    health_zero = 1'b1;
    frame();
    health_zero = 1'b0;
    checks++;
    if (pose_sel !== 4'd8) begin
      errors++;
      $display("FAIL dead_entry pose=%0d expected 8", pose_sel);
    end
    for (int k = 0; k < 100; k++) begin
      {btn_left, btn_right, btn_jump, btn_crouch, btn_punch, btn_kick, btn_block} =
        7'($urandom_range(0, 127));
      frame();
      checks++;
      if (pose_sel !== 4'd8 || attack_active !== 1'b0) begin
        errors++;
        $display("FAIL dead_absorb k=%0d pose=%0d atk=%b expected 8/0", k, pose_sel, attack_active);
      end
    end
    clear_buttons();
    Reset_n = 1'b0;
    #3;
    Reset_n = 1'b1;
    tick();
    checks++;
    if (pose_sel !== 4'd0) begin
      errors++;
      $display("FAIL dead_reset pose=%0d expected 0", pose_sel);
    end
  endtask

  task automatic test_pixel;
    int ea;
    sprite_x = 10'd100; sprite_y = 10'd50; DrawX = 10'd105; DrawY = 10'd52;
    facing_left = 1'b0;
    tick();
    checks++;
    if (rom_addr !== 14'd197) begin
      errors++;
      $display("FAIL pix_addr rom_addr=%0d expected 197", rom_addr);
    end
    tick();
    checks++;
    if (pix_index !== rom_f(14'd197) || pix_inside !== 1'b1) begin
      errors++;
      $display("FAIL pix_data idx=%0d inside=%b expected %0d/1", pix_index, pix_inside,
               rom_f(14'd197));
    end
    facing_left = 1'b1;
`ifdef ZFO_MIRROR_EN
    ea = 282;
`else
    ea = 197;
`endif
    tick();
    checks++;
    if (rom_addr !== 14'(ea)) begin
      errors++;
      $display("FAIL pix_mirror_addr rom_addr=%0d expected %0d", rom_addr, ea);
    end
    DrawX = 10'd99;
    tick(); tick();
    checks++;
    if (pix_inside !== 1'b0 || pix_index !== 4'd0 || rom_addr !== 14'd0) begin
      errors++;
      $display("FAIL pix_left_edge inside=%b idx=%0d addr=%0d expected 0/0/0",
               pix_inside, pix_index, rom_addr);
    end
    facing_left = 1'b0;
  endtask

  task automatic test_stream;
    int   ea [24];
    logic ei [24];
    int   dx, dy;
    logic fl;
    sprite_x = 10'd300; sprite_y = 10'd200;
    for (int i = 0; i < 24; i++) begin
      dx = 290 + i * 5;
      case (i % 4)
        0: dy = 199;
        1: dy = 200;
        2: dy = 327;
        default: dy = 328;
      endcase
      fl = i[1];
      DrawX = 10'(dx); DrawY = 10'(dy); facing_left = fl;
      ea[i] = exp_addr(dx, dy, 300, 200, fl);
      ei[i] = exp_in(dx, dy, 300, 200);
      tick();
      checks++;
      if (rom_addr !== 14'(ea[i])) begin
        errors++;
        $display("FAIL stream_addr i=%0d rom_addr=%0d expected %0d", i, rom_addr, ea[i]);
      end
      if (i > 0) begin
        checks++;
        if (pix_inside !== ei[i-1] ||
            pix_index !== (ei[i-1] ? rom_f(14'(ea[i-1])) : 4'd0)) begin
          errors++;
          $display("FAIL stream_pix i=%0d inside=%b idx=%0d expected %b/%0d", i, pix_inside,
                   pix_index, ei[i-1], ei[i-1] ? rom_f(14'(ea[i-1])) : 4'd0);
        end
      end
    end
    facing_left = 1'b0;
  endtask

  task automatic test_pipe_reset;
    sprite_x = 10'd0; sprite_y = 10'd0; DrawX = 10'd3; DrawY = 10'd1;
    tick(); tick();
    checks++;
    if (pix_inside !== 1'b1) begin
      errors++;
      $display("FAIL pipe_prefill inside=%b expected 1", pix_inside);
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if (pix_inside !== 1'b0 || rom_addr !== 14'd0 || pix_index !== 4'd0) begin
      errors++;
      $display("FAIL pipe_async_clear inside=%b addr=%0d idx=%0d expected 0/0/0",
               pix_inside, rom_addr, pix_index);
    end
    tick();
    Reset_n = 1'b1;
    tick();
    checks++;
    if (rom_addr !== 14'd99 || pix_inside !== 1'b0) begin
      errors++;
      $display("FAIL pipe_after1 addr=%0d inside=%b expected 99/0", rom_addr, pix_inside);
    end
    tick();
    checks++;
    if (pix_inside !== 1'b1 || pix_index !== rom_f(14'd99)) begin
      errors++;
      $display("FAIL pipe_after2 inside=%b idx=%0d expected 1/%0d", pix_inside, pix_index,
               rom_f(14'd99));
    end
  endtask

  initial begin
    test_reset();
    test_punch();
    test_crouchpunch(1'b1);
    test_crouchpunch(1'b0);
    test_move_block();
    test_dead();
    test_pixel();
    test_stream();
    test_pipe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
